// File: rtl/bcd_display_scan.sv
// Time-multiplexed 5-digit common-anode 7-segment driver with per-frame BCD
// capture, leading-zero blanking, live decimal points and inter-digit dead time.
module bcd_display_scan #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] bcd,
   input  logic        lz_en,
   input  logic [4:0]  dp_mask,
   output logic [4:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame
);

   localparam int              CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0]   CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]   CNT_BLANK = CW'(BLANK_CYC);

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [19:0]   shd;

   logic       tick;
   logic       last_digit;
   logic       dead;
   logic [3:0] nib;
   logic       blank;
   logic       dp_sel;
   logic [4:0] an_d;
   logic [6:0] seg_d;
   logic       dp_d;

   assign tick       = (cnt == CNT_LAST);
   assign last_digit = (idx == 3'd4);

   if (BLANK_CYC > 0) begin : g_dead
      assign dead = (cnt < CNT_BLANK);
   end else begin : g_nodead
      assign dead = 1'b0;
   end

   // Digit mux; a digit is blanked when it and every more significant nibble are zero.
   always_comb begin
      nib    = '0;
      blank  = 1'b0;
      dp_sel = 1'b0;
      an_d   = '1;
      for (int unsigned i = 0; i < 5; i++) begin
         if (idx == 3'(i)) begin
            nib     = shd[4*i +: 4];
            blank   = lz_en && (i != 0) && ((shd >> (4*i)) == '0);
            dp_sel  = dp_mask[i];
            an_d[i] = 1'b0;
         end
      end

      case (nib)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         default: seg_d = 7'b0111111;
      endcase
      if (blank) seg_d = '1;
      dp_d = ~dp_sel;

      if (dead) begin
         an_d  = '1;
         seg_d = '1;
         dp_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         idx   <= '0;
         shd   <= '0;
         an    <= '1;
         seg   <= '1;
         dp    <= 1'b1;
         frame <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) idx <= last_digit ? 3'd0 : idx + 3'd1;
         if (tick && last_digit) shd <= bcd;
         frame <= tick && last_digit;
         an    <= an_d;
         seg   <= seg_d;
         dp    <= dp_d;
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan: directed scenarios plus random
// traffic compared every cycle against a frame-position reference model.
module tb_bcd_display_scan;

   localparam int SD = 8;
   localparam int BC = 2;
   localparam int FL = 5 * SD;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] bcd;
   logic        lz_en;
   logic [4:0]  dp_mask;
   logic [4:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;

   always #5 clk = ~clk;

   bcd_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk     (clk),
      .reset   (reset),
      .bcd     (bcd),
      .lz_en   (lz_en),
      .dp_mask (dp_mask),
      .an      (an),
      .seg     (seg),
      .dp      (dp),
      .frame   (frame)
   );

   int errors = 0;
   int checks = 0;
   int pos    = 0;         // position within frame of the current cycle
   int cyc    = 0;
   int last_frame = -1;
   logic [19:0] mshd = '0;

   function automatic logic [6:0] segof(input logic [3:0] d);
      logic [6:0] lut [10];
      lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      if (d > 4'd9) return 7'b0111111;
      return lut[d];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      logic [4:0] ean;
      logic [6:0] eseg;
      logic       edp;
      logic       efr;
      int         i;
      int         c;
      logic       blank;
      logic [3:0] nib;
      if (reset) begin
         ean = 5'h1f; eseg = 7'h7f; edp = 1'b1; efr = 1'b0;
      end else begin
         i   = pos / SD;
         c   = pos % SD;
         efr = (pos == FL - 1);
         if (c < BC) begin
            ean = 5'h1f; eseg = 7'h7f; edp = 1'b1;
         end else begin
            ean   = ~(5'b00001 << i);
            nib   = 4'((mshd >> (4*i)) & 20'hf);
            blank = lz_en && (i > 0) && ((mshd >> (4*i)) == 20'h0);
            eseg  = blank ? 7'h7f : segof(nib);
            edp   = ~dp_mask[i];
         end
      end
      if (reset) begin
         pos = 0; mshd = '0; last_frame = -1;
      end else begin
         if (pos == FL - 1) mshd = bcd;
         pos = (pos + 1) % FL;
      end
      @(posedge clk);
      #1;
      cyc++;
      check("an", 32'(an), 32'(ean));
      check("seg", 32'(seg), 32'(eseg));
      check("dp", 32'(dp), 32'(edp));
      check("frame", 32'(frame), 32'(efr));
      check("an_onehot0", 32'($countones(~an) <= 1), 32'd1);
      if (frame === 1'b1) begin
         if (last_frame >= 0) check("frame_gap", 32'(cyc - last_frame), 32'(FL));
         last_frame = cyc;
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      reset = 1'b1; bcd = '0; lz_en = 1'b1; dp_mask = '0;
      run(3);
      reset = 1'b0;

      // startup and first frame of zeros, bcd changed mid-frame
      run(20);
      bcd = 20'h12345;
      run(60);
      bcd = 20'h99999;
      run(60);

      // leading zeros with and without blanking
      bcd = 20'h00070;
      run(80);
      lz_en = 1'b0;
      run(40);

      // invalid nibble stops blanking; live decimal point
      lz_en = 1'b1; bcd = 20'h0A000; dp_mask = 5'b00100;
      run(80);

      // reset mid-frame at idx 3, cnt 5
      for (int k = 0; k < FL && pos != 3*SD + 5; k++) step();
      check("reach_mid", 32'(pos), 32'(3*SD + 5));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_idx", 32'(dut.idx), 32'd0);
      check("rst_shd", 32'(dut.shd), 32'd0);
      check("rst_cnt", 32'(dut.cnt), 32'd0);
      run(90);

      // random traffic, including invalid nibbles and occasional resets
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 9) == 0) bcd = 20'($urandom);
         if ($urandom_range(0, 3) == 0) dp_mask = 5'($urandom);
         if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
         reset = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;
      run(45);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed driver for a 5-digit common-anode 7-segment display. It consumes the 20-bit packed BCD word produced by the binary-to-BCD converter and scans one digit at a time. It captures the BCD word once per scan frame, so digits never tear mid-frame. It supports leading-zero blanking, per-digit decimal points and an inter-digit dead time for anti-ghosting. All display outputs are registered and connect directly to board pins.

## Interface
- `SCAN_DIV`, 50000: clock cycles each digit is selected; legal range ≥2.
- `BLANK_CYC`, 4: dead-time cycles at the start of each digit slot; legal range 0 ≤ BLANK_CYC < SCAN_DIV.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `bcd`  in  20  packed BCD: digit i = `bcd[4i+3:4i]`, digit 0 least significant.
- `lz_en`  in  1  1 = blank leading zeros.
- `dp_mask`  in  5  bit i = 1 lights the decimal point of digit i; sampled live, not frame-captured.
- `an`  out  5  digit enables, active-low; `an[0]` = rightmost (digit 0).
- `seg`  out  7  segments, active-low, order {g,f,e,d,c,b,a}.
- `dp`  out  1  decimal point, active-low.
- `frame`  out  1  one-cycle pulse marking a new frame capture.

## Operation
- **Prescaler `cnt`** runs 0..SCAN_DIV-1 and wraps. A "tick" is a cycle with `cnt == SCAN_DIV-1`.
- **Digit index `idx`** runs 0..4 and advances on a tick. It wraps 4→0.
- **Shadow register `shd`** (20 bits) loads `bcd` on a tick with `idx == 4`, i.e. at the frame boundary. It holds otherwise.
- **Digit selection:** the displayed nibble is `shd[4*idx+3:4*idx]`.
- **Segment encoding:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles 10–15 show a dash, 0111111 (only g lit).
- **Leading-zero blanking:** when `lz_en == 1`, digit i (i ≥ 1) is blanked if nibbles i..4 of `shd` are all 0.
  - A blanked digit drives `seg = 1111111`, but `an` for that digit still asserts and `dp` still follows `dp_mask`.
  - Digit 0 is never blanked.
  - Invalid nibbles count as nonzero.
- **Dead time:** while `cnt < BLANK_CYC`:
  - `an = 11111`
  - `seg = 1111111`
  - `dp = 1`
- **Active slot:** outside dead time:
  - `an` = all ones except bit `idx` = 0.
  - `dp = ~dp_mask[idx]`.
- **Reset values:**
  - `cnt = 0`, `idx = 0`, `shd = 0`
  - `an = 11111`, `seg = 1111111`, `dp = 1`, `frame = 0`

## Timing
- `an`, `seg`, `dp` and `frame` are registered from the current `cnt`, `idx`, `shd` and `dp_mask`. This gives exactly 1 cycle of latency.
- Cycle 0 is defined as the first cycle with `reset` low.
  - `cnt = 0` at cycle 0.
  - With `BLANK_CYC = 0`, `an = 11110` from cycle 1.
  - Otherwise digit 0 first appears at cycle `BLANK_CYC + 1`.
- Each digit is visible for SCAN_DIV − BLANK_CYC cycles. A frame lasts 5·SCAN_DIV cycles.
- `frame` is high for exactly one cycle, the cycle after `shd` loads. Its period is 5·SCAN_DIV cycles.
- A `bcd` change is visible no earlier than the next frame boundary plus 1 cycle. `bcd` changes mid-frame are ignored until the boundary.
- The first frame after reset displays `shd = 0`: "0" on digit 0 with `lz_en = 1`, or 00000 with `lz_en = 0`.
- **Reset mid-scan:** asserting `reset` in any cycle forces all reset values at the next edge, regardless of `cnt` or `idx`. `shd` is cleared; the pending frame capture is discarded.
- `lz_en` and `dp_mask` act combinationally into the output register, so a change appears after 1 cycle.
- `an` never has more than one bit low in any cycle.

## Test plan
- **Reset and startup:** `SCAN_DIV = 8`, `BLANK_CYC = 2`, reset held 3 cycles, then released.
  - Cycles 1–2: `an = 11111`.
  - Cycles 3–8: `an = 11110`, `seg = 1000000`.
  - Cycles 11–16: `an = 11101`.
  - `frame` pulses at cycle 40.
- **Frame capture:** drive `bcd = 20'h12345` mid-frame 1.
  - Frame 1 still shows zeros.
  - From frame 2: digit 4..0 show `seg` for 1, 2, 3, 4, 5 respectively.
  - Change `bcd` to 20'h99999 mid-frame 2: no effect until frame 3.
- **Leading zeros:** `bcd = 20'h00070`, `lz_en = 1`.
  - Digits 4, 3, 2 show `seg = 1111111` while their `an` bit asserts.
  - Digit 1 shows 1111000; digit 0 shows 1000000.
  - With `lz_en = 0`, digits 4, 3, 2 show 1000000.
- **Invalid BCD and decimal point:** `bcd = 20'h0A000`, `dp_mask = 00100`.
  - Digit 3 shows 0111111 and is not blanked, so digit 4 blanks but digit 3 does not.
  - `dp = 0` only during the active slot of digit 2.
- **Reset mid-frame:** assert `reset` for 1 cycle at `idx = 3`, `cnt = 5`.
  - Next cycle: `an = 11111`, `seg = 1111111`, `frame = 0`, `idx = 0`, `shd = 0`.
  - The scan restarts per the startup sequence.
- **Invariant (all runs):** `an` has at most one zero bit; `frame` spacing is exactly 5·SCAN_DIV cycles.
